// File: rtl/seq_deser_8b_frame_rx.sv
// ----------------------------------------------------------------------------
// seq_deser_8b_frame_rx
//   Framed serial-in, parallel-out receiver. Waits for a start bit (sin=1),
//   collects 8 data bits MSB-first, optionally checks one parity bit, and
//   presents each byte through a single-entry valid/ready output register.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   bit strobe, sin sampled only when en=1
//   sin       in   serial data bit
//   out_val   out  out_data/out_perr hold a valid byte
//   out_rdy   in   consumer accepts when out_val && out_rdy
//   out_data  out  assembled byte, first data bit in [7]
//   out_perr  out  parity mismatch for out_data (0 when PARITY_EN=0)
//   overflow  out  sticky, a completed byte was dropped
// ----------------------------------------------------------------------------
module seq_deser_8b_frame_rx #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sin,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] out_data,
    output logic       out_perr,
    output logic       overflow
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                out_val_q, out_val_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_perr_q, out_perr_d;
    logic                overflow_q, overflow_d;

    logic                done_c;
    logic [DATA_W-1:0]   byte_c;
    logic                perr_c;
    logic                last_data_c;

    assign last_data_c = (cnt_q == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en=0 cycles hold the frame state
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_IDLE: if (sin) state_d = ST_DATA;
                ST_DATA: if (last_data_c) state_d = PARITY_EN ? ST_PAR : ST_IDLE;
                ST_PAR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic: shifting, byte completion and the handshake
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        done_c     = 1'b0;
        byte_c     = shift_q;
        perr_c     = 1'b0;
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_perr_d = out_perr_q;
        overflow_d = overflow_q;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (sin) cnt_d = '0;
                end
                ST_DATA: begin
                    shift_d = {shift_q[DATA_W-2:0], sin};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_data_c && !PARITY_EN) begin
                        done_c = 1'b1;
                        byte_c = {shift_q[DATA_W-2:0], sin};
                    end
                end
                ST_PAR: begin
                    done_c = 1'b1;
                    byte_c = shift_q;
                    perr_c = (^{shift_q, sin}) ^ PARITY_ODD;
                end
                default: ;
            endcase
        end

        // A completion can reuse the slot freed by an accept on the same edge
        if (done_c) begin
            if (!out_val_q || out_rdy) begin
                out_val_d  = 1'b1;
                out_data_d = byte_c;
                out_perr_d = perr_c;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_val_q && out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_perr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_perr_q <= out_perr_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_val  = out_val_q;
    assign out_data = out_data_q;
    assign out_perr = out_perr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_deser_8b_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_seq_deser_8b_frame_rx
//   Self-checking bench: directed frame table, multi-cycle corner sequences,
//   a PARITY_EN=0 instance, and a randomized stream against a frame-level model.
// ----------------------------------------------------------------------------
module tb_seq_deser_8b_frame_rx;

    logic       clk;
    logic       reset;
    logic       en, sin, out_rdy;
    logic       out_val, out_perr, overflow;
    logic [7:0] out_data;

    logic       en2, sin2, out_rdy2;
    logic       out_val2, out_perr2, overflow2;
    logic [7:0] out_data2;

    int n_checks = 0;
    int n_errors = 0;

    seq_deser_8b_frame_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .sin(sin),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_perr(out_perr), .overflow(overflow)
    );

    seq_deser_8b_frame_rx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
        .clk(clk), .reset(reset), .en(en2), .sin(sin2),
        .out_val(out_val2), .out_rdy(out_rdy2), .out_data(out_data2),
        .out_perr(out_perr2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       toggle;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    typedef struct {
        logic       b;
        logic       last;
        logic [7:0] d;
        logic       perr;
    } sbit_t;

    vec_t  vecs[7];
    sbit_t stream[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one frame into the parity instance; out_rdy applies only on the last bit
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic toggle,
                              input logic rdy_last, input logic exp_val_before);
        logic [9:0] bits;
        bits = {1'b1, d, pbit};
        for (int i = 9; i >= 0; i--) begin
            if (i == 0) begin
                chk("val_before_last", 32'(out_val), 32'(exp_val_before));
                out_rdy = rdy_last;
            end
            en  = 1'b1;
            sin = bits[i];
            step();
            out_rdy = 1'b0;
            if (toggle && i != 0) begin
                en  = 1'b0;
                sin = ~bits[i];
                step();
            end
        end
        en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    logic       m_val, m_data_ok, m_perr, m_ovf;
    logic [7:0] m_data;

    initial begin
        reset = 1'b0; en = 1'b0; sin = 1'b0; out_rdy = 1'b0;
        en2 = 1'b0; sin2 = 1'b0; out_rdy2 = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};

        step();
        chk("rst_val", 32'(out_val), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_perr", 32'(out_perr), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_val_np", 32'(out_val2), 32'(0));
        step();
        reset = 1'b1;
        step();

        // Directed frame table
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].toggle, 1'b0, 1'b0);
            chk("tbl_val", 32'(out_val), 32'(1));
            chk("tbl_data", 32'(out_data), 32'(vecs[i].exp_data));
            chk("tbl_perr", 32'(out_perr), 32'(vecs[i].exp_perr));
            step();
            chk("tbl_val_hold", 32'(out_val), 32'(1));
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
            chk("tbl_val_clr", 32'(out_val), 32'(0));
            chk("tbl_data_held", 32'(out_data), 32'(vecs[i].exp_data));
            chk("tbl_ovf", 32'(overflow), 32'(0));
        end

        // Two frames without accept: second byte dropped
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_data", 32'(out_data), 32'(8'h11));
        chk("ovf_val", 32'(out_val), 32'(1));
        chk("ovf_flag", 32'(overflow), 32'(1));
        step();
        chk("ovf_sticky", 32'(overflow), 32'(1));
        pulse_reset();
        chk("ovf_cleared", 32'(overflow), 32'(0));

        // Accept coincides with completion: no bubble, no overflow
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("same_edge_data", 32'(out_data), 32'(8'h22));
        chk("same_edge_val", 32'(out_val), 32'(1));
        chk("same_edge_ovf", 32'(overflow), 32'(0));
        step();
        chk("same_edge_val2", 32'(out_val), 32'(1));

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            en  = 1'b1;
            sin = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        en = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_val", 32'(out_val), 32'(0));
        chk("midrst_data", 32'(out_data), 32'(0));
        chk("midrst_perr", 32'(out_perr), 32'(0));
        step();
        reset = 1'b1;
        step();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_ff_data", 32'(out_data), 32'(8'hFF));
        chk("midrst_ff_perr", 32'(out_perr), 32'(0));
        chk("midrst_ff_val", 32'(out_val), 32'(1));

        // No-parity instance: 0x81 completes after the 8th data bit
        begin
            logic [8:0] b2;
            b2 = {1'b1, 8'h81};
            for (int i = 8; i >= 0; i--) begin
                if (i == 0) chk("np_val_before", 32'(out_val2), 32'(0));
                en2  = 1'b1;
                sin2 = b2[i];
                step();
            end
            en2 = 1'b0;
            chk("np_val", 32'(out_val2), 32'(1));
            chk("np_data", 32'(out_data2), 32'(8'h81));
            chk("np_perr", 32'(out_perr2), 32'(0));
            chk("np_ovf", 32'(overflow2), 32'(0));
        end

        // Randomized stream against a frame-level model with a one-entry output slot
        pulse_reset();
        step();
        for (int f = 0; f < 60; f++) begin
            int   idle;
            logic [7:0] d;
            logic p;
            idle = int'($urandom_range(0, 3));
            d    = 8'($urandom);
            p    = 1'($urandom_range(0, 1));
            for (int k = 0; k < idle; k++) stream.push_back('{1'b0, 1'b0, 8'h00, 1'b0});
            stream.push_back('{1'b1, 1'b0, 8'h00, 1'b0});
            for (int k = 7; k >= 0; k--) stream.push_back('{d[k], 1'b0, 8'h00, 1'b0});
            stream.push_back('{p, 1'b1, d, 1'(($countones(d) + int'(p)) % 2)});
        end
        m_val = 1'b0; m_data = 8'h00; m_perr = 1'b0; m_ovf = 1'b0; m_data_ok = 1'b1;
        for (int cyc = 0; cyc < 3000 && stream.size() > 0; cyc++) begin
            logic  e, r, comp;
            sbit_t sb;
            e    = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 2) != 0);
            comp = 1'b0;
            sb   = '{1'b0, 1'b0, 8'h00, 1'b0};
            if (e) begin
                sb   = stream.pop_front();
                sin  = sb.b;
                comp = sb.last;
            end else begin
                sin = 1'($urandom_range(0, 1));
            end
            en      = e;
            out_rdy = r;
            if (comp) begin
                if (!m_val || r) begin
                    m_val = 1'b1; m_data = sb.d; m_perr = sb.perr;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_val && r) begin
                m_val = 1'b0;
            end
            step();
            chk("rnd_val", 32'(out_val), 32'(m_val));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
            if (m_val) begin
                chk("rnd_data", 32'(out_data), 32'(m_data));
                chk("rnd_perr", 32'(out_perr), 32'(m_perr));
            end
        end
        chk("rnd_stream_drained", 32'(stream.size()), 32'(0));
        en = 1'b0; out_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
